// File: rtl/mem_req_master_pkg.sv
// Shared types and constants for the memory request master slice.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_req_master_if.sv
// Pipeline request/response handshake plus the memory subsystem bus.
interface mem_req_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_hit;
  logic        resp_err;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  DataOut, Done, Stall, CacheHit, err,
    output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    output Addr, DataIn, Rd, Wr
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    output DataOut, Done, Stall, CacheHit, err,
    input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    input  Addr, DataIn, Rd, Wr
  );
endinterface

// File: rtl/mem_req_master_timer.sv
// Clear/enable counter that saturates at all-ones, with an equality compare against LIMIT.
module mem_req_timer #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_req_master.sv
// Single-outstanding load/store initiator: strobe once, hold Addr/DataIn, wait for Done or timeout.
// Define MEM_REQ_PERF_EN to add hit/miss/timeout performance counters.
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  mem_req_if.master bus
`ifdef MEM_REQ_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] perf_hits,
  output logic [15:0] perf_misses,
  output logic [7:0]  perf_timeouts
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic        op_reg;
  logic        req_ready_reg;
  logic        rd_reg;
  logic        wr_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] resp_rdata_reg;
  logic        resp_valid_reg;
  logic        resp_hit_reg;
  logic        resp_err_reg;
  logic        resp_timeout_reg;
  logic        err_sticky_reg;
  logic [7:0]  wait_count_unused;
  logic        wait_expired;
  logic        stall_unused;
  logic        accept;
  logic        misaligned;

  assign accept       = req_ready_reg & bus.req_valid;
  assign misaligned   = ALIGN_CHECK & bus.req_addr[0];
  assign stall_unused = bus.Stall;

  // Counts WAIT cycles; cleared during the strobe so the first WAIT cycle sees 0.
  mem_req_timer #(.W(8), .LIMIT(TIMEOUT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_reg == STROBE),
    .en      (state_reg == WAIT),
    .count   (wait_count_unused),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      op_reg           <= OP_LOAD;
      req_ready_reg    <= 1'b1;
      rd_reg           <= 1'b0;
      wr_reg           <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      resp_rdata_reg   <= '0;
      resp_valid_reg   <= 1'b0;
      resp_hit_reg     <= 1'b0;
      resp_err_reg     <= 1'b0;
      resp_timeout_reg <= 1'b0;
      err_sticky_reg   <= 1'b0;
    end else begin
      // Strobes and response fields are pulses; they default low every cycle.
      rd_reg           <= 1'b0;
      wr_reg           <= 1'b0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      resp_hit_reg     <= 1'b0;
      resp_err_reg     <= 1'b0;
      resp_timeout_reg <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (accept) begin
            addr_reg       <= bus.req_addr;
            wdata_reg      <= bus.req_wdata;
            op_reg         <= bus.req_wr;
            err_sticky_reg <= 1'b0;
            if (misaligned) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              req_ready_reg  <= 1'b1;
            end else begin
              state_reg     <= STROBE;
              rd_reg        <= (bus.req_wr == OP_LOAD);
              wr_reg        <= (bus.req_wr == OP_STORE);
              req_ready_reg <= 1'b0;
            end
          end else begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
          end
        end
        STROBE, WAIT: begin
          err_sticky_reg <= err_sticky_reg | bus.err;
          if (bus.Done) begin
            state_reg      <= RESP;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= (op_reg == OP_LOAD) ? bus.DataOut : 16'h0000;
            resp_hit_reg   <= bus.CacheHit;
            resp_err_reg   <= bus.err | err_sticky_reg;
          end else if ((state_reg == WAIT) && wait_expired) begin
            state_reg        <= RESP;
            req_ready_reg    <= 1'b1;
            resp_valid_reg   <= 1'b1;
            resp_err_reg     <= 1'b1;
            resp_timeout_reg <= 1'b1;
          end else begin
            state_reg <= WAIT;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_hit   = resp_hit_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.Addr       = addr_reg;
  assign bus.DataIn     = wdata_reg;
  assign bus.Rd         = rd_reg;
  assign bus.Wr         = wr_reg;

`ifdef MEM_REQ_PERF_EN
  logic hits_sat_unused;
  logic misses_sat_unused;
  logic timeouts_sat_unused;

  mem_req_timer #(.W(16)) u_perf_hits (
    .clk     (clk),
    .rst     (rst),
    .clr     (perf_clr),
    .en      (resp_valid_reg & resp_hit_reg),
    .count   (perf_hits),
    .expired (hits_sat_unused)
  );

  // A miss is a completed response with neither hit nor error.
  mem_req_timer #(.W(16)) u_perf_misses (
    .clk     (clk),
    .rst     (rst),
    .clr     (perf_clr),
    .en      (resp_valid_reg & ~resp_hit_reg & ~resp_err_reg),
    .count   (perf_misses),
    .expired (misses_sat_unused)
  );

  mem_req_timer #(.W(8)) u_perf_timeouts (
    .clk     (clk),
    .rst     (rst),
    .clr     (perf_clr),
    .en      (resp_valid_reg & resp_timeout_reg),
    .count   (perf_timeouts),
    .expired (timeouts_sat_unused)
  );
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a response scoreboard and a memory responder model.
module tb_mem_req_master;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   rd_cnt;
  int   wr_cnt;
  int   resp_num;

  // Memory responder configuration: Done after done_delay negedges from the strobe (-1 = never).
  int          done_delay;
  int          err_at;
  logic [15:0] cfg_data;
  logic        cfg_hit;
  logic        stray;
  int          resp_k;
  bit          resp_active;

  typedef struct {
    logic [15:0] rdata;
    logic        hit;
    logic        err;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];

  mem_req_if bus();

`ifdef MEM_REQ_PERF_EN
  logic        perf_clr;
  logic [15:0] perf_hits;
  logic [15:0] perf_misses;
  logic [7:0]  perf_timeouts;
  assign perf_clr = 1'b0;
`endif

  mem_req_master #(.TIMEOUT_CYCLES(8), .ALIGN_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_REQ_PERF_EN
    ,
    .perf_clr      (perf_clr),
    .perf_hits     (perf_hits),
    .perf_misses   (perf_misses),
    .perf_timeouts (perf_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory subsystem model, updated on the falling edge.
  initial begin
    resp_active  = 1'b0;
    resp_k       = 0;
    bus.Done     = 1'b0;
    bus.DataOut  = '0;
    bus.CacheHit = 1'b0;
    bus.err      = 1'b0;
    bus.Stall    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Rd || bus.Wr) begin
        resp_active = 1'b1;
        resp_k      = 0;
      end else if (resp_active) begin
        resp_k++;
      end
      bus.Done     = stray | (resp_active && (resp_k == done_delay));
      bus.DataOut  = bus.Done ? cfg_data : 16'h0000;
      bus.CacheHit = bus.Done ? cfg_hit : 1'b0;
      bus.err      = resp_active && (resp_k == err_at);
      bus.Stall    = resp_active && (resp_k < done_delay);
      if (resp_active && (resp_k == done_delay)) resp_active = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid.
  initial begin
    rd_cnt   = 0;
    wr_cnt   = 0;
    resp_num = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.Rd) rd_cnt++;
        if (bus.Wr) wr_cnt++;
        if (bus.resp_valid) begin
          resp_num++;
          $display("resp %0d: cyc=%0d rdata=0x%04h hit=%0b err=%0b",
                   resp_num, cyc, bus.resp_rdata, bus.resp_hit, bus.resp_err);
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
            chk("resp_hit",   32'(bus.resp_hit),   32'(e.hit));
            chk("resp_err",   32'(bus.resp_err),   32'(e.err));
            chk("resp_cycle", 32'(cyc),            32'(e.at_cyc));
          end
        end else begin
          chk("idle_resp_fields", {15'd0, bus.resp_rdata, bus.resp_hit}, 32'd0);
          chk("idle_resp_err", 32'(bus.resp_err), 32'd0);
        end
      end
    end
  end

  // Present a request, wait for acceptance, optionally post the expected response.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] e_rdata, input logic e_hit, input logic e_err,
                       input int n_wait, input bit push, output int acc_edge);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    acc_edge = -1;
    if (!ok) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_edge      = cyc;
      bus.req_valid = 1'b0;
      $display("req: wr=%0b addr=0x%04h wdata=0x%04h accepted at cyc=%0d", wr, addr, wdata, acc_edge);
      if (push) begin
        e.rdata  = e_rdata;
        e.hit    = e_hit;
        e.err    = e_err;
        e.at_cyc = acc_edge + 1 + n_wait;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("resp_missing", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mem(input int d, input int e_at, input logic [15:0] data, input logic hit);
    done_delay = d;
    err_at     = e_at;
    cfg_data   = data;
    cfg_hit    = hit;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    total         = 0;
    bad           = 0;
    stray         = 1'b0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    set_mem(-1, -1, 16'h0000, 1'b0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rd",         32'(bus.Rd),         32'd0);
    chk("rst_wr",         32'(bus.Wr),         32'd0);
    chk("rst_addr",       32'(bus.Addr),       32'd0);
    chk("rst_datain",     32'(bus.DataIn),     32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Load, Done in the strobe cycle
    rd_cnt = 0; wr_cnt = 0;
    set_mem(0, -1, 16'hBEEF, 1'b1);
    issue(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 0, 1'b1, e0);
    drain();
    chk("load_rd_pulses", 32'(rd_cnt), 32'd1);
    chk("load_wr_pulses", 32'(wr_cnt), 32'd0);

    // Store, Done 5 cycles after the strobe with Stall meanwhile
    rd_cnt = 0; wr_cnt = 0;
    set_mem(5, -1, 16'hFFFF, 1'b0);
    issue(1'b1, 16'h0102, 16'h1234, 16'h0000, 1'b0, 1'b0, 5, 1'b1, e0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("store_addr_hold", 32'(bus.Addr),   32'h0102);
      chk("store_data_hold", 32'(bus.DataIn), 32'h1234);
    end
    drain();
    chk("store_wr_pulses", 32'(wr_cnt), 32'd1);
    chk("store_rd_pulses", 32'(rd_cnt), 32'd0);

    // Misaligned load is rejected locally
    rd_cnt = 0; wr_cnt = 0;
    set_mem(0, -1, 16'h7777, 1'b1);
    issue(1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1, -1, 1'b1, e0);
    drain();
    chk("misalign_rd", 32'(rd_cnt), 32'd0);
    chk("misalign_wr", 32'(wr_cnt), 32'd0);

    // Timeout after 8 WAIT cycles, then a stray Done while idle
    set_mem(-1, -1, 16'h9999, 1'b1);
    issue(1'b0, 16'h0044, 16'h0000, 16'h0000, 1'b0, 1'b1, 8, 1'b1, e0);
    drain();
    @(negedge clk);
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    set_mem(1, -1, 16'h5555, 1'b0);
    issue(1'b0, 16'h0050, 16'h0000, 16'h5555, 1'b0, 1'b0, 1, 1'b1, e0);
    drain();

    // Subsystem err in a WAIT cycle is sticky until the response
    set_mem(3, 1, 16'h0A0A, 1'b1);
    issue(1'b0, 16'h0060, 16'h0000, 16'h0A0A, 1'b1, 1'b1, 3, 1'b1, e0);
    drain();
    set_mem(0, -1, 16'h1111, 1'b1);
    issue(1'b0, 16'h0062, 16'h0000, 16'h1111, 1'b1, 1'b0, 0, 1'b1, e0);
    drain();

    // Back-to-back: second request accepted in the RESP cycle
    set_mem(0, -1, 16'h2222, 1'b1);
    issue(1'b1, 16'h0010, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 0, 1'b1, e0);
    issue(1'b0, 16'h0020, 16'h0000, 16'h2222, 1'b1, 1'b0, 0, 1'b1, e1);
    chk("b2b_accept_gap", 32'(e1 - e0), 32'd2);
    drain();

    // Reset during WAIT abandons the transaction
    rd_cnt = 0; wr_cnt = 0;
    set_mem(-1, -1, 16'h0000, 1'b0);
    issue(1'b0, 16'h0070, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, e0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_rd",         32'(bus.Rd),         32'd0);
    chk("midrst_addr",       32'(bus.Addr),       32'd0);
    chk("midrst_datain",     32'(bus.DataIn),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_rd_pulses", 32'(rd_cnt), 32'd1);

    // Normal operation after reset
    set_mem(2, -1, 16'h3C3C, 1'b0);
    issue(1'b0, 16'h0080, 16'h0000, 16'h3C3C, 1'b0, 1'b0, 2, 1'b1, e0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
